// File: rtl/fifo_unpacker_if.sv
// Bus bundle between the read side of a 36-bit FIFO, the unpacker and the
// half-word consumer. The master modport is the unpacker's view (it pops the
// FIFO and produces half-words); the slave modport is the surrounding
// logic's view (it owns the FIFO and consumes the half-words).
interface fifo_unpacker_if;
   logic [35:0] rdata;
   logic        rempty;
   logic        ren;
   logic        flush;
   logic [15:0] dout;
   logic [1:0]  dout_ch;
   logic        dout_last;
   logic        dout_valid;
   logic        dout_ready;
   logic [15:0] words_cnt;

   modport master (
      input  rdata,
      input  rempty,
      input  flush,
      input  dout_ready,
      output ren,
      output dout,
      output dout_ch,
      output dout_last,
      output dout_valid,
      output words_cnt
   );

   modport slave (
      output rdata,
      output rempty,
      output flush,
      output dout_ready,
      input  ren,
      input  dout,
      input  dout_ch,
      input  dout_last,
      input  dout_valid,
      input  words_cnt
   );
endinterface

// File: rtl/fifo_unpacker.sv
// Pops 36-bit words from a FIFO whose read data settles RD_LAT cycles after
// the read pointer moves, and splits each word into one or two 16-bit beats
// on a valid/ready stream. Word layout: [35] last, [34] single (low half
// only), [33:32] channel, [31:16] high half, [15:0] low half.
module fifo_unpacker #(
   parameter int RD_LAT = 2
) (
   input logic             clk,
   input logic             rst,
   fifo_unpacker_if.master bus
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SETTLE  = 2'd1;
   localparam logic [1:0] ST_EMIT_LO = 2'd2;
   localparam logic [1:0] ST_EMIT_HI = 2'd3;

   // The settle window is RD_LAT cycles long, the last of which is the
   // capture cycle, so the counter starts one below the latency.
   localparam logic [2:0] SETTLE_LOAD = 3'(RD_LAT - 1);

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic [2:0]  settle_cnt;
   logic [35:0] hold;
   logic        dout_valid_q;
   logic [15:0] pop_count;
   logic        capture;
   logic        accept;
   logic        settle_start;

   // A pop happens only at the end of a full settle window with data still
   // present; flush vetoes it so the word stays in the FIFO for a retry.
   assign capture      = (state == ST_SETTLE) && (settle_cnt == 3'd0) &&
                         !bus.rempty && !bus.flush;
   assign accept       = dout_valid_q && bus.dout_ready;
   assign settle_start = (state == ST_IDLE) && !bus.rempty && !bus.flush;

   // Next-state selection; flush overrides everything and returns to idle.
   always_comb begin
      state_nxt = state;
      if (bus.flush) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!bus.rempty) state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
               if (bus.rempty)                state_nxt = ST_IDLE;
               else if (settle_cnt == 3'd0)   state_nxt = ST_EMIT_LO;
            end
            ST_EMIT_LO: begin
               if (accept) state_nxt = hold[34] ? ST_IDLE : ST_EMIT_HI;
            end
            ST_EMIT_HI: begin
               if (accept) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // State register plus a registered valid that is high exactly while a
   // beat is being presented.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         dout_valid_q <= 1'b0;
      end else begin
         state        <= state_nxt;
         dout_valid_q <= (state_nxt == ST_EMIT_LO) || (state_nxt == ST_EMIT_HI);
      end
   end

   // Settle counter: loaded on entry to the settle window, counts down to 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         settle_cnt <= 3'd0;
      end else if (settle_start) begin
         settle_cnt <= SETTLE_LOAD;
      end else if ((state == ST_SETTLE) && (settle_cnt != 3'd0)) begin
         settle_cnt <= settle_cnt - 3'd1;
      end
   end

   // Hold register: rdata is looked at only in the capture cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold <= 36'd0;
      end else if (capture) begin
         hold <= bus.rdata;
      end
   end

   // Free-running count of words popped; wraps silently at 16 bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pop_count <= 16'd0;
      end else if (capture) begin
         pop_count <= pop_count + 16'd1;
      end
   end

   // Beat fields are decoded from the hold register and forced to zero when
   // no beat is on offer, so they read 0 in idle, settle and reset.
   always_comb begin
      bus.dout      = 16'd0;
      bus.dout_ch   = 2'd0;
      bus.dout_last = 1'b0;
      case (state)
         ST_EMIT_LO: begin
            bus.dout      = hold[15:0];
            bus.dout_ch   = hold[33:32];
            bus.dout_last = hold[35] & hold[34];
         end
         ST_EMIT_HI: begin
            bus.dout      = hold[31:16];
            bus.dout_ch   = hold[33:32];
            bus.dout_last = hold[35];
         end
         default: begin
            bus.dout      = 16'd0;
            bus.dout_ch   = 2'd0;
            bus.dout_last = 1'b0;
         end
      endcase
   end

   assign bus.ren        = capture;
   assign bus.dout_valid = dout_valid_q;
   assign bus.words_cnt  = pop_count;

endmodule

// File: tb/tb_fifo_unpacker.sv
// Self-checking bench for fifo_unpacker. The FIFO is a queue of words whose
// head only becomes readable RD_LAT cycles after the last pop or after the
// FIFO stopped looking empty; outside that window rdata carries junk. The
// expected consumer stream is a queue of beats derived from each popped word.
module tb_fifo_unpacker;

   localparam int RD_LAT = 2;

   typedef struct packed {
      logic [15:0] data;
      logic [1:0]  ch;
      logic        last;
   } beat_t;

   logic clk;
   logic rst;

   fifo_unpacker_if bus ();

   fifo_unpacker #(.RD_LAT(RD_LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cycle = 0;
   logic [35:0] fifo_q[$];
   beat_t       exp_q[$];
   beat_t       seen_q[$];
   int          ren_log[$];
   int          run_len = 0;
   int          age = 0;
   logic [15:0] exp_cnt = 16'd0;
   logic        exp_ren = 1'b0;

   task automatic checkVal(input string name, input logic [35:0] act, input logic [35:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got 'h%0h, required 'h%0h", name, act, req);
      end
   endtask

   task automatic checkInt(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic checkBeat(input string name, input int idx, input logic [15:0] d,
                            input logic [1:0] ch, input logic l);
      if (idx < seen_q.size()) begin
         checkVal(name, 36'(seen_q[idx]), 36'({d, ch, l}));
      end else begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: got no beat, required data 'h%0h", name, d);
      end
   endtask

   // Compare every DUT output with the model for the current cycle.
   task automatic checkOutput();
      checkVal("ren", 36'(bus.ren), 36'(exp_ren));
      checkVal("dout_valid", 36'(bus.dout_valid), 36'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
         checkVal("dout", 36'(bus.dout), 36'(exp_q[0].data));
         checkVal("dout_ch", 36'(bus.dout_ch), 36'(exp_q[0].ch));
         checkVal("dout_last", 36'(bus.dout_last), 36'(exp_q[0].last));
      end
      checkVal("words_cnt", 36'(bus.words_cnt), 36'(exp_cnt));
   endtask

   // One clock cycle: drive inputs after the falling edge, predict, compare,
   // then advance the model to what the next rising edge must produce.
   // A pop is due on the (RD_LAT+1)-th consecutive cycle in which no beat is
   // pending, the FIFO shows data and no flush is requested.
   task automatic applyStimulus(input logic flush_v, input logic ready_v, input logic glitch_v);
      logic        rempty_v;
      logic [31:0] junk_lo;
      logic [31:0] junk_hi;
      logic [35:0] word;
      int          cand;
      @(negedge clk);
      cycle++;
      rempty_v = (fifo_q.size() == 0) || glitch_v;
      junk_lo  = $urandom;
      junk_hi  = $urandom;
      bus.rempty     = rempty_v;
      bus.flush      = flush_v;
      bus.dout_ready = ready_v;
      if (!rempty_v && age >= RD_LAT) bus.rdata = fifo_q[0];
      else                            bus.rdata = {junk_hi[3:0], junk_lo};
      cand    = (exp_q.size() == 0 && !rempty_v && !flush_v) ? run_len + 1 : 0;
      exp_ren = (cand == RD_LAT + 1);
      run_len = exp_ren ? 0 : cand;
      #1;
      checkOutput();
      if (bus.ren) ren_log.push_back(cycle);
      if (bus.dout_valid && ready_v && !flush_v)
         seen_q.push_back(beat_t'{bus.dout, bus.dout_ch, bus.dout_last});
      if (flush_v) exp_q.delete();
      else if (exp_q.size() > 0 && ready_v) void'(exp_q.pop_front());
      if (exp_ren) begin
         word    = fifo_q.pop_front();
         exp_cnt = exp_cnt + 16'd1;
         exp_q.push_back(beat_t'{word[15:0], word[33:32], word[35] & word[34]});
         if (!word[34]) exp_q.push_back(beat_t'{word[31:16], word[33:32], word[35]});
      end
      age = (rempty_v || exp_ren) ? 0 : age + 1;
   endtask

   // Asynchronous reset between edges; every output must drop at once.
   task automatic applyReset();
      #2;
      rst        = 1'b1;
      bus.rempty = 1'b1;
      bus.flush  = 1'b0;
      #1;
      checkVal("reset ren", 36'(bus.ren), 36'd0);
      checkVal("reset dout_valid", 36'(bus.dout_valid), 36'd0);
      checkVal("reset dout", 36'(bus.dout), 36'd0);
      checkVal("reset dout_ch", 36'(bus.dout_ch), 36'd0);
      checkVal("reset dout_last", 36'(bus.dout_last), 36'd0);
      checkVal("reset words_cnt", 36'(bus.words_cnt), 36'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      run_len = 0;
      age     = 0;
      exp_cnt = 16'd0;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          n0;
      int          s0;
      int          c0;
      int          held;
      int          guard;
      logic [31:0] r_lo;
      logic [31:0] r_hi;

      rst            = 1'b1;
      bus.rdata      = 36'd0;
      bus.rempty     = 1'b1;
      bus.flush      = 1'b0;
      bus.dout_ready = 1'b1;
      applyReset();
      repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);

      $display("[TB] two-beat word");
      fifo_q.push_back(36'h0_BEEF_1234);
      n0 = ren_log.size(); s0 = seen_q.size(); c0 = cycle + 1;
      repeat (10) applyStimulus(1'b0, 1'b1, 1'b0);
      checkInt("t1 ren count", ren_log.size() - n0, 1);
      if (ren_log.size() > n0) checkInt("t1 ren offset", ren_log[n0] - c0, 2);
      checkInt("t1 beat count", seen_q.size() - s0, 2);
      checkBeat("t1 beat0", s0, 16'h1234, 2'd0, 1'b0);
      checkBeat("t1 beat1", s0 + 1, 16'hBEEF, 2'd0, 1'b0);
      checkVal("t1 words_cnt", 36'(bus.words_cnt), 36'd1);

      $display("[TB] single-half word");
      fifo_q.push_back(36'hF_0000_00AA);
      s0 = seen_q.size();
      repeat (10) applyStimulus(1'b0, 1'b1, 1'b0);
      checkInt("t2 beat count", seen_q.size() - s0, 1);
      checkBeat("t2 beat0", s0, 16'h00AA, 2'd3, 1'b1);
      checkVal("t2 words_cnt", 36'(bus.words_cnt), 36'd2);

      $display("[TB] consumer stall");
      fifo_q.push_back(36'h8_5678_9ABC);
      fifo_q.push_back(36'h4_0000_0055);
      n0 = ren_log.size(); s0 = seen_q.size(); held = 0;
      repeat (RD_LAT + 1) applyStimulus(1'b0, 1'b0, 1'b0);
      repeat (5) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         if (bus.dout_valid === 1'b1 && bus.dout === 16'h9ABC) held++;
      end
      checkInt("t3 held cycles", held, 5);
      checkInt("t3 ren during stall", ren_log.size() - n0, 1);
      repeat (15) applyStimulus(1'b0, 1'b1, 1'b0);
      checkBeat("t3 beat0", s0, 16'h9ABC, 2'd0, 1'b0);
      checkBeat("t3 beat1", s0 + 1, 16'h5678, 2'd0, 1'b1);
      checkBeat("t3 beat2", s0 + 2, 16'h0055, 2'd0, 1'b0);
      checkVal("t3 words_cnt", 36'(bus.words_cnt), 36'd4);

      $display("[TB] empty glitch during settle");
      fifo_q.push_back(36'h1_0000_0777);
      n0 = ren_log.size(); c0 = cycle + 1;
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1);
      repeat (12) applyStimulus(1'b0, 1'b1, 1'b0);
      checkInt("t4 ren count", ren_log.size() - n0, 1);
      if (ren_log.size() > n0) checkInt("t4 ren offset", ren_log[n0] - c0, 4);

      $display("[TB] flush in capture cycle");
      fifo_q.push_back(36'h2_0000_0999);
      n0 = ren_log.size(); c0 = cycle + 1;
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkVal("t5 words_cnt after flush", 36'(bus.words_cnt), 36'd5);
      repeat (12) applyStimulus(1'b0, 1'b1, 1'b0);
      checkInt("t5 ren count", ren_log.size() - n0, 1);
      if (ren_log.size() > n0) checkInt("t5 ren offset", ren_log[n0] - c0, 5);
      checkVal("t5 words_cnt", 36'(bus.words_cnt), 36'd6);

      $display("[TB] counter wrap");
      #1;
      force dut.pop_count = 16'hFFFF;
      #1;
      release dut.pop_count;
      exp_cnt = 16'hFFFF;
      fifo_q.push_back(36'h0_0000_0001);
      repeat (10) applyStimulus(1'b0, 1'b1, 1'b0);
      checkVal("t6 words_cnt wrap", 36'(bus.words_cnt), 36'd0);

      $display("[TB] reset during high half");
      fifo_q.push_back(36'hB_3333_4444);
      repeat (RD_LAT + 1) applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkVal("t7 high half shown", 36'(bus.dout), 36'h3333);
      applyReset();

      $display("[TB] randomized traffic");
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(99, 0) < 30 && fifo_q.size() < 8) begin
            r_lo = $urandom;
            r_hi = $urandom;
            fifo_q.push_back({r_hi[3:0], r_lo});
         end
         applyStimulus($urandom_range(99, 0) < 3, $urandom_range(99, 0) < 70,
                       $urandom_range(99, 0) < 5);
         if (i == 2000) applyReset();
      end

      guard = 0;
      while ((fifo_q.size() > 0 || exp_q.size() > 0) && guard < 500) begin
         applyStimulus(1'b0, 1'b1, 1'b0);
         guard++;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_unpacker.md
FIFO_UNPACKER -- requirements
Module: fifo_unpacker

Interface
REQ-001 SHALL have parameter: RD_LAT, 2, cycles from a read-pointer change to valid FIFO read data (legal 1..7).
REQ-002 SHALL have port: clk  input  1  single clock; all logic rising-edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: rdata  input  36  FIFO read word: [35] last, [34] single (low half only), [33:32] channel, [31:16] high half, [15:0] low half.
REQ-005 SHALL have port: rempty  input  1  FIFO empty, read-clock domain.
REQ-006 SHALL have port: ren  output  1  FIFO pop, one-cycle pulse.
REQ-007 SHALL have port: flush  input  1  synchronous discard of the word held or pending.
REQ-008 SHALL have port: dout  output  16  unpacked half-word.
REQ-009 SHALL have port: dout_ch  output  2  channel of dout.
REQ-010 SHALL have port: dout_last  output  1  dout ends a packet.
REQ-011 SHALL have port: dout_valid  output  1  dout/dout_ch/dout_last valid.
REQ-012 SHALL have port: dout_ready  input  1  consumer accepts on dout_valid & dout_ready.
REQ-013 SHALL have port: words_cnt  output  16  count of words popped, wraps.

Function
REQ-014 SHALL implement states IDLE, SETTLE, EMIT_LO, EMIT_HI.
REQ-015 IDLE: rempty=0 -> SETTLE with settle counter loaded to RD_LAT-1; otherwise stay.
REQ-016 SETTLE: counter decrements each cycle; rempty=1 in any SETTLE cycle -> IDLE, no pop.
REQ-017 SETTLE at counter 0 with rempty=0 (capture cycle): rdata registered into 36-bit hold, ren=1 that cycle only, words_cnt+1, -> EMIT_LO.
REQ-018 ren SHALL never assert outside a capture cycle; consecutive ren pulses SHALL be at least RD_LAT+1 cycles apart.
REQ-019 EMIT_LO: dout_valid=1, dout=hold[15:0], dout_ch=hold[33:32], dout_last=hold[35]&hold[34].
REQ-020 EMIT_LO accept: hold[34]=1 -> IDLE; else -> EMIT_HI.
REQ-021 EMIT_HI: dout_valid=1, dout=hold[31:16], dout_ch=hold[33:32], dout_last=hold[35]; accept -> IDLE.
REQ-022 While dout_valid=1 and dout_ready=0, dout/dout_ch/dout_last SHALL hold stable.
REQ-023 dout_valid SHALL be a registered output, 0 in IDLE and SETTLE; first half presented the cycle after capture.
REQ-024 flush=1: next state IDLE, dout_valid=0 next cycle, hold contents ignored; flush in a capture cycle SHALL suppress ren and the words_cnt increment.
REQ-025 flush has priority over accept and capture; rst has priority over flush.
REQ-026 words_cnt SHALL wrap 16'hFFFF -> 16'h0000 without any flag.
REQ-027 rdata SHALL be sampled only in the capture cycle; changes at other times SHALL have no effect.

Reset
REQ-028 rst=1 SHALL immediately force: state IDLE, ren=0, dout_valid=0, dout=0, dout_ch=0, dout_last=0, words_cnt=0, hold=0, settle counter=0.
REQ-029 rst asserted mid-packet SHALL drop the held word; after release the block restarts from IDLE, re-evaluating rempty.

Verification
REQ-030 rempty=0, rdata=36'h0_BEEF_1234 (last=0, single=0, ch=0), dout_ready=1, RD_LAT=2 -> ren pulse 2 cycles after leaving IDLE; then dout 16'h1234 then 16'hBEEF, dout_last=0 both, words_cnt=1.
REQ-031 rdata=36'hF_0000_00AA (last=1, single=1, ch=3) -> exactly one dout 16'h00AA, dout_ch=3, dout_last=1; no EMIT_HI beat.
REQ-032 dout_ready=0 for 5 cycles during EMIT_LO -> dout_valid and dout held unchanged 5 cycles; no further ren; release -> remaining half delivered.
REQ-033 rempty toggles 1 in the SETTLE cycle -> no ren, return to IDLE; rempty back to 0 -> full RD_LAT settle repeated before capture.
REQ-034 flush asserted in capture cycle -> ren stays 0, words_cnt unchanged, dout_valid 0; word captured on the next settle.
REQ-035 Preload words_cnt to 16'hFFFF via 65535 pops (or force) -> next pop yields 16'h0000; rst mid EMIT_HI -> all outputs 0 immediately.
